mesh_port_adapter: RTL

- Shares one mesh network access port (the read/write/destination-address/data edge interface) between NUM_CLIENTS requesters.
- Merges the clients through a round-robin arbiter and a request FIFO.
- Issues one request per cycle into the mesh edge router and tracks outstanding reads with a tag FIFO.
- Routes each returning read to the client that issued it.
- Generalises the fixed single-requester-per-port arrangement of the mesh top level.

---
 rtl/mesh_port_adapter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mesh_port_adapter.sv
// mesh_port_adapter: round-robin merge of NUM_CLIENTS requesters onto one mesh edge port,
// with in-order read tagging. Optional read watchdog enabled by MESH_PORT_READ_TIMEOUT_EN.
module mesh_port_adapter #(
  parameter int NUM_CLIENTS     = 4,
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLIENTS-1:0]            req_valid,
  input  logic [NUM_CLIENTS-1:0]            req_write,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_CLIENTS-1:0]            req_ready,
  output logic [NUM_CLIENTS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic [ADDR_WIDTH-1:0]             destinationAddressOut,
  output logic                              readOut,
  output logic                              writeOut,
  output logic [DATA_WIDTH-1:0]             dataOut,
  input  logic                              readReadyIn,
  input  logic [DATA_WIDTH-1:0]             dataIn,
`ifdef MESH_PORT_READ_TIMEOUT_EN
  output logic                              rsp_timeout,
`endif
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              err_unexpected
);

  localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int RW = $clog2(REQ_DEPTH);
  localparam int TW = $clog2(MAX_OUTSTANDING);
  localparam int EW = CW + 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [RW:0] ReqFullCount = (RW+1)'(REQ_DEPTH);
  localparam logic [TW:0] MaxOutCount  = (TW+1)'(MAX_OUTSTANDING);

  logic [ADDR_WIDTH-1:0] clientAddr [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0] clientData [NUM_CLIENTS];
  logic [CW-1:0]         rotIdx     [NUM_CLIENTS];

  logic [CW-1:0] rrPtrReg;
  logic [CW-1:0] grantIdx;
  logic          grantFound;
  logic          transfer;

  logic [EW-1:0] reqMem [REQ_DEPTH];
  logic [RW-1:0] reqWrPtrReg;
  logic [RW-1:0] reqRdPtrReg;
  logic [RW:0]   reqCountReg;
  logic [EW-1:0] reqEntry;
  logic [EW-1:0] headEntry;
  logic [CW-1:0] headId;
  logic          headWrite;
  logic [ADDR_WIDTH-1:0] headAddr;
  logic [DATA_WIDTH-1:0] headData;
  logic          canIssue;
  logic          issueRead;

  logic [CW-1:0] tagMem [MAX_OUTSTANDING];
  logic [TW-1:0] tagWrPtrReg;
  logic [TW-1:0] tagRdPtrReg;
  logic [TW:0]   outstandingReg;
  logic [CW-1:0] tagHead;
  logic          tagPop;
  logic          timeoutHit;
  logic [NUM_CLIENTS-1:0] rspValidNext;

  // Per-client slices and the rotated scan order starting at the round-robin pointer
  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
    assign clientAddr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign clientData[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign rotIdx[gi]     = CW'((int'(rrPtrReg) + gi) % NUM_CLIENTS);
  end

  always_comb begin
    grantIdx   = '0;
    grantFound = 1'b0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (!grantFound && req_valid[rotIdx[k]]) begin
        grantIdx   = rotIdx[k];
        grantFound = 1'b1;
      end
    end
  end

  assign transfer = grantFound && (reqCountReg != ReqFullCount) && !reset;

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[grantIdx] = 1'b1;
  end

  assign reqEntry  = {grantIdx, req_write[grantIdx], clientAddr[grantIdx], clientData[grantIdx]};
  assign headEntry = reqMem[reqRdPtrReg];
  assign headId    = headEntry[EW-1 -: CW];
  assign headWrite = headEntry[ADDR_WIDTH+DATA_WIDTH];
  assign headAddr  = headEntry[DATA_WIDTH +: ADDR_WIDTH];
  assign headData  = headEntry[DATA_WIDTH-1:0];

  // A read at the head waits for a free slot and holds back everything behind it
  assign canIssue  = (reqCountReg != '0) && (headWrite || (outstandingReg < MaxOutCount));
  assign issueRead = canIssue && !headWrite;

  assign tagHead = tagMem[tagRdPtrReg];
  assign tagPop  = (readReadyIn && (outstandingReg != '0)) || timeoutHit;

  always_comb begin
    rspValidNext = '0;
    if (tagPop) rspValidNext[tagHead] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (transfer)  reqMem[reqWrPtrReg] <= reqEntry;
    if (issueRead) tagMem[tagWrPtrReg] <= headId;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrPtrReg              <= '0;
      reqWrPtrReg           <= '0;
      reqRdPtrReg           <= '0;
      reqCountReg           <= '0;
      tagWrPtrReg           <= '0;
      tagRdPtrReg           <= '0;
      outstandingReg        <= '0;
      readOut               <= 1'b0;
      writeOut              <= 1'b0;
      destinationAddressOut <= '0;
      dataOut               <= '0;
      rsp_valid             <= '0;
      rsp_data              <= '0;
      err_unexpected        <= 1'b0;
    end else begin
      if (transfer) begin
        reqWrPtrReg <= reqWrPtrReg + 1'b1;
        rrPtrReg    <= (grantIdx == CW'(NUM_CLIENTS-1)) ? '0 : grantIdx + 1'b1;
      end
      if (canIssue) reqRdPtrReg <= reqRdPtrReg + 1'b1;
      reqCountReg <= reqCountReg + {{RW{1'b0}}, transfer} - {{RW{1'b0}}, canIssue};

      readOut  <= issueRead;
      writeOut <= canIssue && headWrite;
      if (canIssue) begin
        destinationAddressOut <= headAddr;
        dataOut               <= headData;
      end

      if (issueRead) tagWrPtrReg <= tagWrPtrReg + 1'b1;
      if (tagPop)    tagRdPtrReg <= tagRdPtrReg + 1'b1;
      outstandingReg <= outstandingReg + {{TW{1'b0}}, issueRead} - {{TW{1'b0}}, tagPop};

      rsp_valid <= rspValidNext;
      if (tagPop) rsp_data <= readReadyIn ? dataIn : '0;
      if (readReadyIn && (outstandingReg == '0)) err_unexpected <= 1'b1;
    end
  end

`ifdef MESH_PORT_READ_TIMEOUT_EN
  localparam int AgeW = $clog2(TIMEOUT_CYCLES + 1);
  logic [AgeW-1:0] ageReg;

  // A real response in the same cycle always takes precedence over the watchdog
  assign timeoutHit = (outstandingReg != '0) && !readReadyIn &&
                      (ageReg == AgeW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ageReg      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_timeout <= timeoutHit;
      if ((outstandingReg == '0) || tagPop) ageReg <= '0;
      else                                  ageReg <= ageReg + 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  assign outstanding = outstandingReg;

endmodule
